pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Generates the stall, freeze, bubble and flush enables for the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB register banks.
- Covers three events: load-use hazards, taken branches resolved in decode, and multi-cycle data-memory accesses through a req/ready handshake, with a timeout fault.
- Provides saturating stall and flush performance counters.

Parameters:
REG_ADDR_W, 5, register-index width
MEM_TIMEOUT, 255, max cycles spent in MEM_WAIT before entering FAULT (≥2)
CNT_W, 32, perf-counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
id_rs1  in  REG_ADDR_W  rs1 of the instruction in ID
id_rs2  in  REG_ADDR_W  rs2 of the instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  REG_ADDR_W  rd held in ID_EX
ex_mem_read  in  1  ID_EX holds a load
id_branch_taken  in  1  decode resolved a taken branch/jump
mem_req  in  1  EX_MEM holds a load/store needing memory
mem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC update enable
if_id_write  out  1  IF_ID load enable
if_id_flush  out  1  clear IF_ID to NOP
id_ex_flush  out  1  load a bubble (control=0) into ID_EX
ex_mem_write  out  1  ID_EX→EX_MEM and EX_MEM→MEM_WB advance enable
mem_wb_bubble  out  1  MEM_WB loads control=0
state  out  2  RUN=0, MEM_WAIT=1, FAULT=2
mem_timeout  out  1  sticky fault flag
stall_count  out  CNT_W  cycles with pc_write=0, excluding FAULT
flush_count  out  CNT_W  cycles with if_id_flush=1

Behaviour:
- Registers: state, 8-bit wait timer, mem_timeout, two counters. All enable outputs are combinational from state and the current inputs.
- Reset (rst=0, async):
  - state=RUN, timer=0, mem_timeout=0, counters=0.
  - All enables forced to 0 while rst=0.
- Default in RUN with no event: pc_write=if_id_write=ex_mem_write=1; all flush/bubble outputs 0.
- Priority in RUN: memory stall > load-use > branch.
- Memory stall, RUN with mem_req=1 and mem_ready=0:
  - pc_write=if_id_write=ex_mem_write=0, mem_wb_bubble=1.
  - Next state MEM_WAIT, timer=1.
  - mem_req=1 with mem_ready=1 in RUN is a single-cycle access: no stall.
- MEM_WAIT:
  - Same freeze outputs while mem_ready=0; timer increments each cycle.
  - mem_ready=1: that cycle outputs the RUN defaults, the pipeline advances, next state RUN, timer=0. Load-use and branch are not evaluated in this cycle.
  - mem_ready=0 with timer==MEM_TIMEOUT: next state FAULT, mem_timeout←1.
- Load-use, RUN with no memory stall, detected when ex_mem_read=1, ex_rd≠0, and (id_uses_rs1 & id_rs1==ex_rd) or (id_uses_rs2 & id_rs2==ex_rd):
  - pc_write=0, if_id_write=0, id_ex_flush=1.
  - ex_mem_write=1, so older instructions keep flowing.
  - Exactly one bubble per hazard, because ex_rd changes on the next cycle.
- Branch, RUN with id_branch_taken=1 and no load-use or memory stall:
  - if_id_flush=1, pc_write=1 (PC takes the branch target), if_id_write=1.
  - A branch masked by load-use is re-evaluated on the next cycle.
- FAULT:
  - All enables 0, mem_wb_bubble=1.
  - Held until reset; ignores mem_ready.
- Counters:
  - stall_count +1 on each non-reset cycle with pc_write=0 and state≠FAULT.
  - flush_count +1 on each cycle with if_id_flush=1.
  - Both saturate at all-ones and never wrap.
- Reset asserted mid-MEM_WAIT: immediate return to RUN; any pending access is abandoned.

Test Plan:
- Reset release, no events → pc_write=if_id_write=ex_mem_write=1, state=0, counters=0.
- ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for one cycle → pc_write=0, if_id_write=0, id_ex_flush=1 for 1 cycle, stall_count=1. Repeat with ex_rd=0 → no stall.
- id_branch_taken=1 for one cycle, no hazard → if_id_flush=1, pc_write=1, flush_count=1. Branch concurrent with load-use → only id_ex_flush=1 that cycle; if_id_flush=1 the next cycle.
- mem_req=1, mem_ready asserted 3 cycles later → state=1 for 3 cycles with freeze outputs, release cycle all writes=1, then state=0, stall_count=3.
- mem_req=1 with mem_ready stuck at 0, MEM_TIMEOUT=4 → state=2 and mem_timeout=1 after 5 cycles; later mem_ready=1 has no effect; rst=0 → state=0, mem_timeout=0.
- Counter saturation with CNT_W=4, 20 stall cycles → stall_count stays 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: the stall, freeze, bubble and flush enables for a
// 5-stage pipeline, a data-memory wait/timeout FSM and saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  id_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_write,
  output logic                  mem_wb_bubble,
  output logic [1:0]            state,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       fault_set;
  logic       load_use;

  assign state = state_q;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    pc_write      = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_write  = 1'b0;
    mem_wb_bubble = 1'b0;
    state_d       = state_q;
    timer_d       = timer_q;
    fault_set     = 1'b0;

    // Enables stay low for as long as reset is held, independent of state.
    if (rst) begin
      unique case (state_q)
        RUN: begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          ex_mem_write = 1'b1;
          if (mem_req && !mem_ready) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
            state_d       = MEM_WAIT;
            timer_d       = 8'd1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end else if (id_branch_taken) begin
            if_id_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            ex_mem_write = 1'b1;
            state_d      = RUN;
            timer_d      = '0;
          end else begin
            mem_wb_bubble = 1'b1;
            if (timer_q == TIMEOUT_VAL) begin
              state_d   = FAULT;
              fault_set = 1'b1;
            end else begin
              timer_d = timer_q + 8'd1;
            end
          end
        end
        FAULT: begin
          mem_wb_bubble = 1'b1;
        end
        default: begin
          state_d = RUN;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      timer_q     <= '0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (fault_set) begin
        mem_timeout <= 1'b1;
      end
      if (!pc_write && (state_q != FAULT) && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
      if (if_id_flush && (flush_count != '1)) begin
        flush_count <= flush_count + 1'b1;
      end
    end
  end

endmodule
